// File: rtl/pll_reset_pkg.sv
// Shared encodings for the PLL reset sequencer.
// State constants stay plain localparams so legacy code can compare against them.
package pll_reset_pkg;

    localparam logic [1:0] ST_WAIT_LOCK = 2'd0;
    localparam logic [1:0] ST_STABILIZE = 2'd1;
    localparam logic [1:0] ST_RUN       = 2'd2;
    localparam logic [1:0] ST_UNUSED    = 2'd3;

    // Where the sequencer lands after an illegal encoding
    localparam logic [1:0] ST_RECOVER   = ST_WAIT_LOCK;

    function automatic int stable_cnt_w(input int cycles);
        int w;
        w = $clog2(cycles);
        return (w < 1) ? 1 : w;
    endfunction

    function automatic logic holds_reset(input logic [1:0] st);
        return st != ST_RUN;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for slow level signals crossing into clk.
// Both stages clear asynchronously on reset.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_reset_sequencer.sv
// Holds sys_reset until the PLL lock has been stable for STABLE_CYCLES.
// Define PLL_RESET_LOSS_COUNT_EN to build the saturating lock-loss counter.
module pll_reset_sequencer
    import pll_reset_pkg::*;
#(
    parameter int STABLE_CYCLES    = 1024,
    parameter int LOSS_COUNT_WIDTH = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        locked,
    input  logic                        soft_reset_req,
    output logic                        sys_reset,
    output logic [1:0]                  state,
    output logic [LOSS_COUNT_WIDTH-1:0] lock_loss_count
);

    localparam int CNT_W = stable_cnt_w(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             locked_s;
    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             sys_reset_q;
    logic             cnt_done;

    sync_2ff #(
        .WIDTH(1)
    ) u_lock_sync (
        .clk  (clk),
        .reset(reset),
        .d    (locked),
        .q    (locked_s)
    );

    assign cnt_done = (cnt_q == CNT_LAST);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_WAIT_LOCK: begin
                cnt_d = '0;
                if (locked_s) begin
                    state_d = ST_STABILIZE;
                end
            end
            ST_STABILIZE: begin
                if (!locked_s) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_done) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                cnt_d = '0;
                // A lock loss wins over a coincident soft request
                if (!locked_s) begin
                    state_d = ST_WAIT_LOCK;
                end else if (soft_reset_req) begin
                    state_d = ST_STABILIZE;
                end
            end
            default: begin
                state_d = ST_RECOVER;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_WAIT_LOCK;
            cnt_q       <= '0;
            sys_reset_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sys_reset_q <= holds_reset(state_d);
        end
    end

`ifdef PLL_RESET_LOSS_COUNT_EN
    logic                        loss_inc;
    logic [LOSS_COUNT_WIDTH-1:0] loss_q;

    assign loss_inc = (state_q == ST_RUN) && !locked_s;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            loss_q <= '0;
        end else if (loss_inc && (loss_q != '1)) begin
            loss_q <= loss_q + 1'b1;
        end
    end

    assign lock_loss_count = loss_q;
`else
    assign lock_loss_count = '0;
`endif

    assign sys_reset = sys_reset_q;
    assign state     = state_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with STABLE_CYCLES=4.
// Loss-count expectations follow PLL_RESET_LOSS_COUNT_EN.
module tb_pll_reset_sequencer;

    localparam int SC = 4;
    localparam int LW = 2;
`ifdef PLL_RESET_LOSS_COUNT_EN
    localparam bit LC_EN = 1'b1;
`else
    localparam bit LC_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          locked;
    logic          soft_reset_req;
    logic          sys_reset;
    logic [1:0]    state;
    logic [LW-1:0] lock_loss_count;

    int compared   = 0;
    int mismatched = 0;

    pll_reset_sequencer #(
        .STABLE_CYCLES   (SC),
        .LOSS_COUNT_WIDTH(LW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .locked         (locked),
        .soft_reset_req (soft_reset_req),
        .sys_reset      (sys_reset),
        .state          (state),
        .lock_loss_count(lock_loss_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] exp_loss(input int n);
        return LC_EN ? 8'(n) : 8'd0;
    endfunction

    // Drop lock in RUN; optionally raise soft_reset_req on the loss edge
    task automatic lose_lock(input bit with_soft, input int n);
        locked = 1'b0;
        step();
        chk("drop_m0_sys", {7'd0, sys_reset}, 8'd0);
        step();
        chk("drop_m1_sys", {7'd0, sys_reset}, 8'd0);
        soft_reset_req = with_soft;
        step();
        soft_reset_req = 1'b0;
        chk("drop_state", {6'd0, state}, 8'd0);
        chk("drop_sys", {7'd0, sys_reset}, 8'd1);
        chk("drop_loss", {6'd0, lock_loss_count}, exp_loss(n));
        locked = 1'b1;
        repeat (6) step();
        chk("relock_sys_hi", {7'd0, sys_reset}, 8'd1);
        step();
        chk("relock_sys_lo", {7'd0, sys_reset}, 8'd0);
        chk("relock_state", {6'd0, state}, 8'd2);
    endtask

    initial begin
        logic [1:0] st_exp [7];
        st_exp = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2};

        reset          = 1'b1;
        locked         = 1'b0;
        soft_reset_req = 1'b0;
        repeat (2) step();
        chk("rst_state", {6'd0, state}, 8'd0);
        chk("rst_sys", {7'd0, sys_reset}, 8'd1);
        chk("rst_loss", {6'd0, lock_loss_count}, 8'd0);

        // Clean bring-up; a soft request mid-STABILIZE must be ignored
        reset  = 1'b0;
        locked = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step();
            soft_reset_req = (i == 3);
            chk("bringup_state", {6'd0, state}, {6'd0, st_exp[i]});
            chk("bringup_sys", {7'd0, sys_reset}, (i < 6) ? 8'd1 : 8'd0);
        end
        soft_reset_req = 1'b0;

        // Async reset mid-RUN, then a one-cycle lock glitch at count 2
        #3 reset = 1'b1;
        #1;
        chk("async_rst_sys", {7'd0, sys_reset}, 8'd1);
        chk("async_rst_state", {6'd0, state}, 8'd0);
        step();
        reset = 1'b0;
        repeat (3) step();
        locked = 1'b0;
        step();
        locked = 1'b1;
        step();
        chk("glitch_stab", {6'd0, state}, 8'd1);
        step();
        chk("glitch_wait", {6'd0, state}, 8'd0);
        chk("glitch_sys", {7'd0, sys_reset}, 8'd1);
        step();
        chk("glitch_restab", {6'd0, state}, 8'd1);
        repeat (3) step();
        chk("glitch_sys_hi", {7'd0, sys_reset}, 8'd1);
        step();
        chk("glitch_sys_lo", {7'd0, sys_reset}, 8'd0);
        chk("glitch_run", {6'd0, state}, 8'd2);

        lose_lock(1'b0, 1);
        lose_lock(1'b0, 2);

        // Soft request from RUN: exactly SC cycles of reset
        soft_reset_req = 1'b1;
        step();
        soft_reset_req = 1'b0;
        chk("soft_state", {6'd0, state}, 8'd1);
        chk("soft_sys0", {7'd0, sys_reset}, 8'd1);
        for (int i = 1; i < SC; i++) begin
            step();
            chk("soft_sys_hi", {7'd0, sys_reset}, 8'd1);
        end
        step();
        chk("soft_sys_lo", {7'd0, sys_reset}, 8'd0);
        chk("soft_run", {6'd0, state}, 8'd2);
        chk("soft_loss", {6'd0, lock_loss_count}, exp_loss(2));

        // Async reset clears the loss count before any edge
        #3 reset = 1'b1;
        #1;
        chk("rst2_sys", {7'd0, sys_reset}, 8'd1);
        chk("rst2_loss", {6'd0, lock_loss_count}, 8'd0);
        step();
        reset = 1'b0;
        repeat (6) step();
        chk("rst2_sys_hi", {7'd0, sys_reset}, 8'd1);
        step();
        chk("rst2_sys_lo", {7'd0, sys_reset}, 8'd0);

        // Loss and soft request together, then saturate
        lose_lock(1'b1, 1);
        lose_lock(1'b0, 2);
        lose_lock(1'b0, 3);
        lose_lock(1'b0, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
